eth_tx_framer: RTL and testbench

Byte-wide Ethernet-style frame generator that sits directly upstream of the frame receiver. It buffers one payload from a host-side byte stream, then emits a complete frame on `data`/`start`: preamble, SFD, destination MAC, source MAC, length, payload and a 4-byte additive checksum field. It is the stimulus source and loopback partner for the receive path.

---
 rtl/eth_tx_framer.sv | 84 ++++++++
 tb/tb_eth_tx_framer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: buffers one host payload, then emits preamble, SFD, MACs, length, payload and additive checksum
module eth_tx_framer #(
  parameter logic [47:0] DEST_MAC = 48'h00_0a_95_9d_68_16,
  parameter logic [47:0] SRC_MAC = 48'h00_00_00_00_00_01,
  parameter int DEPTH = 64,
  parameter int IFG = 12
) (
  input logic clk,
  input logic rst,
  input logic [7:0] in_data,
  input logic in_vld,
  input logic in_last,
  output logic in_ready,
  output logic [7:0] data,
  output logic start,
  output logic busy,
  output logic err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] GAP_END = 16'(IFG - 1);
  typedef enum logic [3:0] {LOAD, PRE, SFD, DST, SRC, LEN, PL, FCS, GAP} state_t;
  state_t state, ns;
  logic [7:0] mem [DEPTH];
  logic [AW:0] cnt;
  logic [15:0] n, idx, ni;
  logic [7:0] sum, nd;
  logic acc, drop, go;
  assign acc = in_vld && in_ready;
  assign drop = cnt[AW];
  assign go = acc && in_last && !drop;
  always_comb begin
    ns = state;
    case (state)
      LOAD: ns = go ? PRE : LOAD;
      PRE: ns = idx == 16'd6 ? SFD : PRE;
      SFD: ns = DST;
      DST: ns = idx == 16'd5 ? SRC : DST;
      SRC: ns = idx == 16'd5 ? LEN : SRC;
      LEN: ns = idx == 16'd1 ? PL : LEN;
      PL: ns = idx == n - 16'd1 ? FCS : PL;
      FCS: ns = idx == 16'd3 ? (IFG == 0 ? LOAD : GAP) : FCS;
      GAP: ns = idx == GAP_END ? LOAD : GAP;
      default: ns = LOAD;
    endcase
    ni = (ns == state && state != LOAD) ? idx + 16'd1 : 16'd0;
    case (ns)
      PRE: nd = 8'h55;
      SFD: nd = 8'hd5;
      DST: nd = DEST_MAC[{ni[2:0], 3'b000} +: 8];
      SRC: nd = SRC_MAC[{ni[2:0], 3'b000} +: 8];
      LEN: nd = ni[0] ? n[15:8] : n[7:0];
      PL: nd = mem[ni[AW-1:0]];
      FCS: nd = ~sum + 8'd1;
      default: nd = 8'h00;
    endcase
  end
  always_ff @(posedge clk)
    if (acc && !drop) mem[cnt[AW-1:0]] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD;
      idx <= '0;
      cnt <= '0;
      n <= '0;
      sum <= '0;
      data <= '0;
      start <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state <= ns;
      idx <= ni;
      data <= nd;
      start <= go;
      busy <= ns != LOAD;
      in_ready <= ns == LOAD;
      err <= acc && in_last && drop;
      sum <= state == LOAD ? 8'd0 : (ns inside {DST, SRC, LEN, PL}) ? sum + nd : sum;
      if (go) n <= 16'(cnt) + 16'd1;
      if (acc && in_last) cnt <= '0;
      else if (acc && !drop) cnt <= cnt + (AW+1)'(1);
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed and randomized back-to-back checks of eth_tx_framer frames
module tb_eth_tx_framer;
  localparam logic [47:0] DMAC = 48'h00_0a_95_9d_68_16;
  localparam logic [47:0] SMAC = 48'h00_00_00_00_00_01;
  localparam int IFG_A = 12;
  typedef logic [7:0] bq_t [$];
  logic clk, rst;
  logic [7:0] in_data, data, in_data0, data0;
  logic in_vld, in_last, in_ready, start, busy, err;
  logic in_vld0, in_last0, in_ready0, start0, busy0, err0;
  int n_chk = 0;
  int n_fail = 0;
  eth_tx_framer #(.DEST_MAC(DMAC), .SRC_MAC(SMAC), .DEPTH(64), .IFG(IFG_A)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_last(in_last),
    .in_ready(in_ready), .data(data), .start(start), .busy(busy), .err(err)
  );
  eth_tx_framer #(.DEST_MAC(DMAC), .SRC_MAC(SMAC), .DEPTH(64), .IFG(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_vld(in_vld0), .in_last(in_last0),
    .in_ready(in_ready0), .data(data0), .start(start0), .busy(busy0), .err(err0)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic build(input bq_t p, output bq_t f);
    logic [47:0] dm, sm;
    logic [15:0] nn;
    logic [7:0] s;
    dm = DMAC;
    sm = SMAC;
    f.delete();
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hd5);
    for (int i = 0; i < 6; i++) f.push_back(dm[8*i +: 8]);
    for (int i = 0; i < 6; i++) f.push_back(sm[8*i +: 8]);
    nn = 16'(p.size());
    f.push_back(nn[7:0]);
    f.push_back(nn[15:8]);
    foreach (p[i]) f.push_back(p[i]);
    s = 8'd0;
    for (int i = 8; i < f.size(); i++) s = s + f[i];
    s = ~s + 8'd1;
    for (int i = 0; i < 4; i++) f.push_back(s);
  endtask
  task automatic push(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    in_data = d;
    in_vld = 1'b1;
    in_last = l;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready=%b, want 1", in_ready);
    end
    tick();
    in_vld = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic send(input bq_t p);
    for (int i = 0; i < p.size(); i++) push(p[i], i == p.size() - 1);
  endtask
  task automatic check_frame(input bq_t e, input string nm);
    for (int k = 0; k < e.size(); k++) begin
      n_chk++;
      if ({start, busy, in_ready, err, data} !== {k == 0, 1'b1, 1'b0, 1'b0, e[k]}) begin
        n_fail++;
        $display("FAIL %s byte %0d: got start=%b busy=%b rdy=%b err=%b data=%h, want start=%b busy=1 rdy=0 err=0 data=%h",
                 nm, k, start, busy, in_ready, err, data, k == 0, e[k]);
      end
      tick();
    end
    for (int g = 0; g < IFG_A; g++) begin
      n_chk++;
      if ({start, busy, in_ready, data} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL %s gap %0d: got start=%b busy=%b rdy=%b data=%h, want 0 1 0 00", nm, g, start, busy, in_ready, data);
      end
      tick();
    end
    n_chk++;
    if ({start, busy, in_ready, data} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL %s idle: got start=%b busy=%b rdy=%b data=%h, want 0 0 1 00", nm, start, busy, in_ready, data);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    in_vld = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    in_vld0 = 1'b0;
    in_last0 = 1'b0;
    in_data0 = 8'h00;
    #1 rst = 1'b1;
    tick();
    n_chk++;
    if ({data, start, busy, err, in_ready, data0, start0, busy0, err0, in_ready0} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h start=%b busy=%b err=%b rdy=%b data0=%h rdy0=%b, want all 0",
               data, start, busy, err, in_ready, data0, in_ready0);
    end
    #3 rst = 1'b0;
    tick();
    n_chk++;
    if ({in_ready, busy, start, data, in_ready0, busy0} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b busy=%b start=%b data=%h rdy0=%b busy0=%b, want 1 0 0 00 1 0",
               in_ready, busy, start, data, in_ready0, busy0);
    end
  endtask
  task automatic test_minimal();
    logic [7:0] m [29] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hd5,
                           8'h16, 8'h68, 8'h9d, 8'h95, 8'h0a, 8'h00,
                           8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h03, 8'h00, 8'h01, 8'h02, 8'h03,
                           8'h3c, 8'h3c, 8'h3c, 8'h3c};
    bq_t e, p;
    foreach (m[i]) e.push_back(m[i]);
    p = '{8'h01, 8'h02, 8'h03};
    send(p);
    check_frame(e, "minimal");
  endtask
  task automatic test_single();
    logic [7:0] m [27] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hd5,
                           8'h16, 8'h68, 8'h9d, 8'h95, 8'h0a, 8'h00,
                           8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h01, 8'h00, 8'hff,
                           8'h45, 8'h45, 8'h45, 8'h45};
    bq_t e;
    foreach (m[i]) e.push_back(m[i]);
    push(8'hff, 1'b1);
    check_frame(e, "single");
  endtask
  task automatic test_full();
    bq_t p, e;
    for (int i = 0; i < 64; i++) p.push_back(8'(i));
    build(p, e);
    send(p);
    check_frame(e, "full64");
  endtask
  task automatic test_overflow();
    bq_t p, e;
    for (int i = 0; i < 65; i++) push(8'(i), i == 64);
    n_chk++;
    if ({err, start, busy, in_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL overflow_err: got err=%b start=%b busy=%b rdy=%b, want 1 0 0 1", err, start, busy, in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++;
      if ({err, start, busy, data} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL overflow_quiet %0d: got err=%b start=%b busy=%b data=%h, want 0 0 0 00", c, err, start, busy, data);
      end
    end
    p = '{8'h5a, 8'ha5};
    build(p, e);
    send(p);
    check_frame(e, "after_overflow");
  endtask
  task automatic test_back_to_back();
    bq_t p, e;
    p = '{8'hc0, 8'hde};
    build(p, e);
    send(p);
    check_frame(e, "b2b_first");
    p = '{8'h77};
    build(p, e);
    push(8'h77, 1'b1);
    check_frame(e, "b2b_second");
  endtask
  task automatic test_reset_mid();
    bq_t p, e;
    for (int i = 0; i < 10; i++) p.push_back(8'ha0 + 8'(i));
    build(p, e);
    send(p);
    for (int k = 0; k < 24; k++) begin
      n_chk++;
      if (data !== e[k]) begin
        n_fail++;
        $display("FAIL pre_reset byte %0d: got data=%h, want %h", k, data, e[k]);
      end
      tick();
    end
    #3 rst = 1'b1;
    #1;
    n_chk++;
    if ({data, start, busy, in_ready, err} !== 12'h0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%h start=%b busy=%b rdy=%b err=%b, want all 0", data, start, busy, in_ready, err);
    end
    tick();
    #3 rst = 1'b0;
    tick();
    n_chk++;
    if ({in_ready, busy, start, data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL post_reset: got rdy=%b busy=%b start=%b data=%h, want 1 0 0 00", in_ready, busy, start, data);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if ({start, busy, data} !== {1'b0, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL no_partial %0d: got start=%b busy=%b data=%h, want 0 0 00", c, start, busy, data);
      end
    end
    p = '{8'h10, 8'h20, 8'h30};
    build(p, e);
    send(p);
    check_frame(e, "after_reset");
  endtask
  task automatic test_backpressure();
    bq_t pay, cap, e;
    logic [7:0] flat [$];
    int lens [$];
    int frames, len, mis;
    logic rdy, bad;
    frames = 0;
    bad = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy = in_ready0;
      if (cyc < 2500) begin
        in_vld0 = 1'b1;
        in_data0 = 8'($urandom);
        in_last0 = ($urandom_range(0, 5) == 0) || pay.size() >= 40;
      end else begin
        in_vld0 = 1'b0;
        in_last0 = 1'b0;
      end
      if (rdy && in_vld0) begin
        pay.push_back(in_data0);
        if (in_last0) begin
          build(pay, e);
          lens.push_back(e.size());
          foreach (e[i]) flat.push_back(e[i]);
          pay.delete();
        end
      end
      tick();
      if (in_ready0 !== !busy0 || err0 !== 1'b0) bad = 1'b1;
      if (busy0) begin
        if (start0 !== (cap.size() == 0)) bad = 1'b1;
        cap.push_back(data0);
      end else if (cap.size() != 0) begin
        n_chk++;
        if (lens.size() == 0) begin
          n_fail++;
          $display("FAIL bp_frame %0d: got %0d bytes, want no frame", frames, cap.size());
        end else begin
          len = lens.pop_front();
          mis = -1;
          for (int i = 0; i < len; i++) begin
            if (i < cap.size() && cap[i] !== flat[0] && mis < 0) mis = i;
            void'(flat.pop_front());
          end
          if (len != cap.size() || mis >= 0 || bad) begin
            n_fail++;
            $display("FAIL bp_frame %0d: got len=%0d first_bad_byte=%0d flags_bad=%b, want len=%0d all bytes match",
                     frames, cap.size(), mis, bad, len);
          end
        end
        frames++;
        bad = 1'b0;
        cap.delete();
      end
    end
    n_chk++;
    if (lens.size() != 0 || frames < 10) begin
      n_fail++;
      $display("FAIL bp_summary: got frames=%0d pending=%0d, want at least 10 frames and 0 pending", frames, lens.size());
    end
  endtask
  initial begin
    test_reset();
    test_minimal();
    test_single();
    test_full();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
